// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared encodings for the LC-3b sequencing controller.
//   State codes, opcode constants, datapath select encodings and the
//   DECODE-state dispatch function.
package lc3b_pkg;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_IR_LD    = 4'd2;
    localparam logic [3:0] S_DECODE   = 4'd3;
    localparam logic [3:0] S_ALU      = 4'd4;
    localparam logic [3:0] S_BR       = 4'd5;
    localparam logic [3:0] S_JMP      = 4'd6;
    localparam logic [3:0] S_JSR_LINK = 4'd7;
    localparam logic [3:0] S_JSR_PC   = 4'd8;
    localparam logic [3:0] S_LEA      = 4'd9;
    localparam logic [3:0] S_LD_MEM   = 4'd10;
    localparam logic [3:0] S_LD_WB    = 4'd11;
    localparam logic [3:0] S_ST_MEM   = 4'd12;
    localparam logic [3:0] S_ERR      = 4'd13;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDW = 4'b0110;
    localparam logic [3:0] OP_STW = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_SHF = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] PC_PLUS2 = 2'd0;
    localparam logic [1:0] PC_OFF9  = 2'd1;
    localparam logic [1:0] PC_OFF11 = 2'd2;
    localparam logic [1:0] PC_BASE  = 2'd3;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    localparam logic [1:0] ALUB_SR2  = 2'd0;
    localparam logic [1:0] ALUB_IMM5 = 2'd1;
    localparam logic [1:0] ALUB_OFF6 = 2'd2;
    localparam logic [1:0] ALUB_ZERO = 2'd3;

    localparam logic [1:0] RFW_ALU  = 2'd0;
    localparam logic [1:0] RFW_MEM  = 2'd1;
    localparam logic [1:0] RFW_PC   = 2'd2;
    localparam logic [1:0] RFW_OFF9 = 2'd3;

    function automatic logic [3:0] decode_next(input logic [3:0] op);
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_SHF: decode_next = S_ALU;
            OP_BR:  decode_next = S_BR;
            OP_JMP: decode_next = S_JMP;
            OP_JSR: decode_next = S_JSR_LINK;
            OP_LEA: decode_next = S_LEA;
            OP_LDW: decode_next = S_LD_MEM;
            OP_STW: decode_next = S_ST_MEM;
            default: decode_next = S_ERR;
        endcase
    endfunction

endpackage

// File: rtl/lc3b_mem_wait_timer.sv
// lc3b_mem_wait_timer: counts wait cycles of a pending memory access and flags timeout.
//   i_clk, i_rst  clock, async active-high reset
//   i_active      controller is in a memory state
//   i_ready       memory completes this cycle
//   o_timeout     TIMEOUT-th consecutive wait cycle with i_ready low
module lc3b_mem_wait_timer
    import lc3b_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    // ready wins over timeout; count is 0 on every memory-state entry because
    // each memory state is left either with ready high or via timeout (both clear it)
    assign o_timeout = i_active & ~i_ready & (r_cnt == W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_cnt <= '0;
        else
            r_cnt <= (i_active & ~i_ready & ~o_timeout) ? r_cnt + 1'b1 : '0;

endmodule

// File: rtl/lc3b_seq_ctrl.sv
// lc3b_seq_ctrl: self-sequencing multicycle LC-3b control unit with memory handshake.
//   Inputs : i_clk, i_rst (async, active-high), i_ir, i_nzp, i_mem_ready
//   Outputs: o_state, o_mem_req, o_mem_wr_n, o_rf_wr_n, o_pc_wr_n, o_ir_wr_n,
//            o_cc_ld_n, o_pc_sel, o_addr_sel, o_alub_sel, o_rfw_sel, o_alu_ctl, o_err
//   Option : LC3B_PERF_CNT_EN adds o_cycle_cnt / o_instret_cnt (CNT_W bits).
//   Outputs decode from the state register and IR/NZP only; mem_ready feeds next state.
module lc3b_seq_ctrl
    import lc3b_pkg::*;
#(
    parameter int IR_W    = 16,
    parameter int STATE_W = 4,
    parameter int TIMEOUT = 15
`ifdef LC3B_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [IR_W-1:0]    i_ir,
    input  logic [2:0]         i_nzp,
    input  logic               i_mem_ready,
    output logic [STATE_W-1:0] o_state,
    output logic               o_mem_req,
    output logic               o_mem_wr_n,
    output logic               o_rf_wr_n,
    output logic               o_pc_wr_n,
    output logic               o_ir_wr_n,
    output logic               o_cc_ld_n,
    output logic [1:0]         o_pc_sel,
    output logic               o_addr_sel,
    output logic [1:0]         o_alub_sel,
    output logic [1:0]         o_rfw_sel,
    output logic [3:0]         o_alu_ctl,
`ifdef LC3B_PERF_CNT_EN
    output logic [CNT_W-1:0]   o_cycle_cnt,
    output logic [CNT_W-1:0]   o_instret_cnt,
`endif
    output logic               o_err
);
    logic [STATE_W-1:0] r_state;
    logic [3:0]         w_cur;
    logic [3:0]         w_next;
    logic               w_mem_state;
    logic               w_timeout;
    logic               w_unused;

    // unused encodings (14, 15 and anything in the upper bits) behave as ERR
    assign w_cur       = (r_state < STATE_W'(14)) ? r_state[3:0] : S_ERR;
    assign w_mem_state = (w_cur == S_FETCH) | (w_cur == S_LD_MEM) | (w_cur == S_ST_MEM);
    assign w_unused    = ^i_ir;
    assign o_state     = r_state;

    lc3b_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (w_mem_state),
        .i_ready   (i_mem_ready),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = S_ERR;
        case (w_cur)
            S_RESET:    w_next = S_FETCH;
            S_FETCH:    w_next = i_mem_ready ? S_IR_LD : w_timeout ? S_ERR : S_FETCH;
            S_IR_LD:    w_next = S_DECODE;
            S_DECODE:   w_next = decode_next(i_ir[IR_W-1 -: 4]);
            S_JSR_LINK: w_next = S_JSR_PC;
            S_LD_MEM:   w_next = i_mem_ready ? S_LD_WB : w_timeout ? S_ERR : S_LD_MEM;
            S_ST_MEM:   w_next = i_mem_ready ? S_FETCH : w_timeout ? S_ERR : S_ST_MEM;
            S_ALU, S_BR, S_JMP, S_JSR_PC, S_LEA, S_LD_WB: w_next = S_FETCH;
            default:    w_next = S_ERR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_state <= STATE_W'(S_RESET);
        else
            r_state <= STATE_W'(w_next);

    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_wr_n = 1'b1;
        o_rf_wr_n  = 1'b1;
        o_pc_wr_n  = 1'b1;
        o_ir_wr_n  = 1'b1;
        o_cc_ld_n  = 1'b1;
        o_pc_sel   = PC_PLUS2;
        o_addr_sel = ADDR_PC;
        o_alub_sel = ALUB_SR2;
        o_rfw_sel  = RFW_ALU;
        o_alu_ctl  = 4'd0;
        o_err      = 1'b0;
        case (w_cur)
            S_FETCH:  o_mem_req = 1'b1;
            S_IR_LD: begin
                o_ir_wr_n = 1'b0;
                o_pc_wr_n = 1'b0;
            end
            S_ALU: begin
                o_rf_wr_n  = 1'b0;
                o_cc_ld_n  = 1'b0;
                o_alub_sel = i_ir[5] ? ALUB_IMM5 : ALUB_SR2;
                o_alu_ctl  = {i_ir[IR_W-1 -: 2], i_ir[5:4]};
            end
            S_BR: begin
                o_pc_sel  = PC_OFF9;
                o_pc_wr_n = ~|(i_ir[11:9] & i_nzp);
            end
            S_JMP: begin
                o_pc_sel  = PC_BASE;
                o_pc_wr_n = 1'b0;
            end
            S_JSR_LINK: begin
                o_rf_wr_n = 1'b0;
                o_rfw_sel = RFW_PC;
            end
            S_JSR_PC: begin
                o_pc_sel  = i_ir[11] ? PC_OFF11 : PC_BASE;
                o_pc_wr_n = 1'b0;
            end
            S_LEA: begin
                o_rf_wr_n = 1'b0;
                o_rfw_sel = RFW_OFF9;
                o_cc_ld_n = 1'b0;
            end
            S_LD_MEM: begin
                o_mem_req  = 1'b1;
                o_addr_sel = ADDR_ALU;
                o_alub_sel = ALUB_OFF6;
            end
            S_LD_WB: begin
                o_rf_wr_n = 1'b0;
                o_rfw_sel = RFW_MEM;
                o_cc_ld_n = 1'b0;
            end
            S_ST_MEM: begin
                o_mem_req  = 1'b1;
                o_mem_wr_n = 1'b0;
                o_addr_sel = ADDR_ALU;
                o_alub_sel = ALUB_OFF6;
            end
            S_ERR:    o_err = 1'b1;
            default:  o_err = 1'b0;
        endcase
    end

`ifdef LC3B_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (w_cur != S_RESET && w_cur != S_ERR)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            // retire = fresh entry into FETCH; the first fetch after reset is not a retirement
            if (w_next == S_FETCH && w_cur != S_FETCH && w_cur != S_RESET)
                r_instret_cnt <= r_instret_cnt + 1'b1;
        end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_lc3b_seq_ctrl.sv
// tb_lc3b_seq_ctrl: directed self-checking bench for lc3b_seq_ctrl (default parameters).
module tb_lc3b_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        rdy;
    logic [3:0]  state;
    logic        mem_req, mem_wr_n, rf_wr_n, pc_wr_n, ir_wr_n, cc_ld_n, addr_sel, err;
    logic [1:0]  pc_sel, alub_sel, rfw_sel;
    logic [3:0]  alu_ctl;
`ifdef LC3B_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sb[$];

    always #5 clk = ~clk;

    lc3b_seq_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ir          (ir),
        .i_nzp         (nzp),
        .i_mem_ready   (rdy),
        .o_state       (state),
        .o_mem_req     (mem_req),
        .o_mem_wr_n    (mem_wr_n),
        .o_rf_wr_n     (rf_wr_n),
        .o_pc_wr_n     (pc_wr_n),
        .o_ir_wr_n     (ir_wr_n),
        .o_cc_ld_n     (cc_ld_n),
        .o_pc_sel      (pc_sel),
        .o_addr_sel    (addr_sel),
        .o_alub_sel    (alub_sel),
        .o_rfw_sel     (rfw_sel),
        .o_alu_ctl     (alu_ctl),
`ifdef LC3B_PERF_CNT_EN
        .o_cycle_cnt   (cycle_cnt),
        .o_instret_cnt (instret_cnt),
`endif
        .o_err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive mem_ready for one edge; expected next state goes through the scoreboard
    task automatic step(input logic r, input logic [3:0] exp, input string tag);
        sb.push_back(exp);
        rdy = r;
        @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(state), 32'(sb.pop_front()));
    endtask

    // FETCH (ready at once) -> IR_LD -> DECODE
    task automatic fetch(input string tag);
        step(1'b1, 4'd2, {tag, "_irld"});
        step(1'b0, 4'd3, {tag, "_dec"});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_err", 32'({err, mem_req}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ir  = 16'h0000;
        nzp = 3'b000;
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_n_outs", 32'({mem_wr_n, rf_wr_n, pc_wr_n, ir_wr_n, cc_ld_n}), 32'h1f);
        chk("rst_sels", 32'({mem_req, pc_sel, addr_sel, alub_sel, rfw_sel, alu_ctl, err}), 0);
        rst = 1'b0;

        // ADD R1,R2,#3 with two fetch waits
        step(1'b0, 4'd1, "rst_to_fetch");
        chk("fetch_req", 32'({mem_req, addr_sel}), 32'b10);
        step(1'b0, 4'd1, "fetch_wait1");
        step(1'b0, 4'd1, "fetch_wait2");
        step(1'b1, 4'd2, "fetch_done");
        chk("irld_ctl", 32'({ir_wr_n, pc_wr_n, pc_sel, mem_req}), 0);
        ir = 16'h12A3;
        step(1'b0, 4'd3, "add_dec");
        step(1'b0, 4'd4, "add_alu");
        chk("add_alub", 32'(alub_sel), 1);
        chk("add_aluctl", 32'(alu_ctl), 32'b0010);
        chk("add_wr", 32'({rf_wr_n, cc_ld_n, rfw_sel, pc_wr_n}), 32'b00001);
        step(1'b0, 4'd1, "add_to_fetch");

        // AND register form
        ir = 16'h5042;
        fetch("and");
        step(1'b0, 4'd4, "and_alu");
        chk("and_alub_aluctl", 32'({alub_sel, alu_ctl}), 32'b00_0100);
        step(1'b0, 4'd1, "and_to_fetch");

        // BRz taken / not taken
        ir  = 16'h0405;
        nzp = 3'b010;
        fetch("brt");
        step(1'b0, 4'd5, "brt_br");
        chk("brt_pc", 32'({pc_wr_n, pc_sel}), 32'b0_01);
        step(1'b0, 4'd1, "brt_to_fetch");
        nzp = 3'b100;
        fetch("brn");
        step(1'b0, 4'd5, "brn_br");
        chk("brn_pc", 32'({pc_wr_n, pc_sel}), 32'b1_01);
        step(1'b0, 4'd1, "brn_to_fetch");

        // JMP
        ir = 16'hC080;
        fetch("jmp");
        step(1'b0, 4'd6, "jmp_st");
        chk("jmp_pc", 32'({pc_wr_n, pc_sel}), 32'b0_11);
        step(1'b0, 4'd1, "jmp_to_fetch");

        // JSR with ir[11]=1
        ir = 16'h4800;
        fetch("jsr");
        step(1'b0, 4'd7, "jsr_link");
        chk("jsr_link_ctl", 32'({rf_wr_n, rfw_sel, pc_wr_n}), 32'b0_10_1);
        step(1'b0, 4'd8, "jsr_pc");
        chk("jsr_pc_ctl", 32'({pc_wr_n, pc_sel, rf_wr_n}), 32'b0_10_1);
        step(1'b0, 4'd1, "jsr_to_fetch");

        // LEA
        ir = 16'hE000;
        fetch("lea");
        step(1'b0, 4'd9, "lea_st");
        chk("lea_ctl", 32'({rf_wr_n, rfw_sel, cc_ld_n}), 32'b0_11_0);
        step(1'b0, 4'd1, "lea_to_fetch");

        // LDW: 14 waits then ready on the timeout cycle (ready wins)
        ir = 16'h6000;
        fetch("ldw");
        step(1'b0, 4'd10, "ldw_mem");
        chk("ldw_mem_ctl", 32'({mem_req, mem_wr_n, addr_sel, alub_sel, alu_ctl}), 32'b1_1_1_10_0000);
        for (int i = 0; i < 14; i++) step(1'b0, 4'd10, "ldw_wait");
        step(1'b1, 4'd11, "ldw_ready_at_limit");
        chk("ldw_wb_ctl", 32'({rf_wr_n, rfw_sel, cc_ld_n, mem_req}), 32'b0_01_0_0);
        step(1'b0, 4'd1, "ldw_to_fetch");

        // STW timing out after 15 low cycles
        ir = 16'h7000;
        fetch("stw");
        step(1'b0, 4'd12, "stw_mem");
        chk("stw_mem_ctl", 32'({mem_req, mem_wr_n, addr_sel, alub_sel}), 32'b1_0_1_10);
        for (int i = 0; i < 14; i++) step(1'b0, 4'd12, "stw_wait");
        step(1'b0, 4'd13, "stw_timeout");
        chk("err_ctl", 32'({err, mem_req, mem_wr_n, rf_wr_n, pc_wr_n}), 32'b1_0_1_1_1);
        step(1'b1, 4'd13, "err_sticky1");
        step(1'b0, 4'd13, "err_sticky2");
        do_reset();

        // TRAP: DECODE then ERR, mem_ready pulses ignored
        ir = 16'hF000;
        step(1'b0, 4'd1, "trap_fetch");
        fetch("trap");
        step(1'b1, 4'd13, "trap_err");
        chk("trap_err_flag", 32'({err, mem_req}), 32'b10);
        step(1'b1, 4'd13, "trap_sticky");
        do_reset();

        // reset in the middle of LD_MEM
        ir = 16'h6000;
        step(1'b0, 4'd1, "mid_fetch");
        fetch("mid");
        step(1'b0, 4'd10, "mid_ldmem");
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_req", 32'(mem_req), 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef LC3B_PERF_CNT_EN
        ir = 16'h12A3;
        step(1'b0, 4'd1, "perf_fetch");
        for (int i = 0; i < 3; i++) begin
            fetch("perf");
            step(1'b0, 4'd4, "perf_alu");
            step(1'b0, 4'd1, "perf_to_fetch");
        end
        chk("instret_cnt", instret_cnt, 3);
        chk("cycle_cnt", cycle_cnt, 12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
